// File: rtl/shift_reg_seq_if.sv
// ---------------------------------------------------------------------------
// shift_reg_seq_if
// Bundles the control, data and status signals of shift_reg_seq.
//   master : drives en, clr, mode, start, amount, d, sin; observes q, sout,
//            busy, done (the user of the register)
//   slave  : the register itself
// Clock and reset are not part of the bundle; they stay plain module ports.
// ---------------------------------------------------------------------------
interface shift_reg_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic             clr;
    logic [2:0]       mode;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output en, clr, mode, start, amount, d, sin,
        input  q, sout, busy, done
    );

    modport slave (
        input  en, clr, mode, start, amount, d, sin,
        output q, sout, busy, done
    );
endinterface

// File: rtl/shift_reg_seq.sv
// ---------------------------------------------------------------------------
// shift_reg_seq
// WIDTH-bit multi-mode register (hold, load, shift, rotate, Galois LFSR,
// clear) with a start/busy/done sequencer that repeats one step `amount`
// times. Used as a cipher state register, serialiser or keystream LFSR.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : shift_reg_seq_if.slave
//     en     : clock enable (clr still acts when en=0)
//     clr    : synchronous clear, aborts a running operation
//     mode   : 000 hold 001 load 010 SHL 011 SHR 100 ROL 101 ROR 110 LFSR 111 clear
//     start  : begin an `amount`-step operation (sampled in IDLE)
//     amount : number of steps for a start operation
//     d      : parallel load data
//     sin    : serial input for SHL (into LSB) and SHR (into MSB)
//     q      : register contents
//     sout   : serial output, combinational
//     busy   : high while a multi-step operation runs
//     done   : one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_reg_seq #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'('hB8),
    parameter int               CNT_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    shift_reg_seq_if.slave bus
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LOAD = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_SHR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ROR  = 3'b101;
    localparam logic [2:0] M_LFSR = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [2:0]       mode_l;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_r;
    logic             busy_r;
    logic             done_r;
    logic [2:0]       eff_mode;

    // One step of the register for a given mode.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             s
    );
        logic [WIDTH-1:0] nxt;
        nxt = cur;
        case (m)
            M_HOLD: nxt = cur;
            M_LOAD: nxt = din;
            M_SHL:  nxt = {cur[WIDTH-2:0], s};
            M_SHR:  nxt = {s, cur[WIDTH-1:1]};
            M_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
            M_LFSR: nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
            M_CLR:  nxt = '0;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Single-step modes finish in one edge even when started with a count.
    function automatic logic is_single(input logic [2:0] m);
        return (m == M_HOLD) || (m == M_LOAD) || (m == M_CLR);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mode_l <= M_HOLD;
            cnt    <= '0;
            q_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.clr) begin
            state  <= IDLE;
            cnt    <= '0;
            q_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.en) begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.start) begin
                        q_r <= step_fn(bus.mode, q_r, bus.d, bus.sin);
                    end else if (bus.amount == '0) begin
                        done_r <= 1'b1;
                    end else begin
                        q_r <= step_fn(bus.mode, q_r, bus.d, bus.sin);
                        if (is_single(bus.mode) || bus.amount == CNT_W'(1)) begin
                            done_r <= 1'b1;
                        end else begin
                            // First step happens now; cnt holds the steps still owed.
                            mode_l <= bus.mode;
                            cnt    <= bus.amount - CNT_W'(1);
                            busy_r <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    q_r <= step_fn(mode_l, q_r, bus.d, bus.sin);
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // sout follows whichever mode will act on the next step.
    assign eff_mode = busy_r ? mode_l : bus.mode;
    assign bus.sout = ((eff_mode == M_SHL) || (eff_mode == M_ROL)) ? q_r[WIDTH-1] : q_r[0];
    assign bus.q    = q_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule
